// File: rtl/eyeriss_pkg.sv
// Shared definitions for the Eyeriss-style PE scratchpads.
package eyeriss_pkg;

    localparam int IFMAP_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } ifmap_spad_state_t;

    // Bit width for an index over n items, never narrower than one bit.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of sliding windows over one row; a zero stride is reported
    // separately, so it maps to 1 here only to keep elaboration arithmetic sane.
    function automatic int num_windows(input int depth, input int kernel, input int stride);
        return (stride == 0) ? 1 : (depth - kernel) / stride + 1;
    endfunction

endpackage

// File: rtl/ifmap_spad_mem.sv
// Ifmap scratchpad storage: register array, one synchronous write port and
// one combinational read port. Contents are intentionally not reset.
module ifmap_spad_mem
    import eyeriss_pkg::*;
#(
    parameter int  DATA_WIDTH = IFMAP_DATA_WIDTH,
    parameter int  DEPTH      = 12,
    localparam int AW         = width_min1(DEPTH)
)(
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write one pixel per enabled cycle.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifmap_spad_ctrl.sv
// PE-local ifmap scratchpad controller: loads one row of DEPTH pixels, then
// replays it to the MAC as KERNEL-pixel windows stepping by STRIDE, pulses
// done and returns to loading. Loading and replay never overlap.
module ifmap_spad_ctrl
    import eyeriss_pkg::*;
#(
    parameter int  DATA_WIDTH = IFMAP_DATA_WIDTH,
    parameter int  DEPTH      = 12,
    parameter int  KERNEL     = 3,
    parameter int  STRIDE     = 1,
    localparam int NUM_OUT    = num_windows(DEPTH, KERNEL, STRIDE),
    localparam int AW         = width_min1(DEPTH),
    localparam int KW         = width_min1(KERNEL),
    localparam int WW         = width_min1(NUM_OUT)
)(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_clear,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_in_ready,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [KW-1:0]         o_out_k,
    output logic [WW-1:0]         o_out_win,
    output logic                  o_out_last,
    output logic                  o_done
);

    generate
        if ((KERNEL > DEPTH) || (STRIDE == 0) ||
            (((DEPTH - KERNEL) % ((STRIDE == 0) ? 1 : STRIDE)) != 0)) begin : g_bad_cfg
            $error("ifmap_spad_ctrl: illegal DEPTH/KERNEL/STRIDE combination");
        end
    endgenerate

    localparam logic [AW-1:0] LP_WR_LAST  = AW'(DEPTH - 1);
    localparam logic [KW-1:0] LP_K_LAST   = KW'(KERNEL - 1);
    localparam logic [WW-1:0] LP_WIN_LAST = WW'(NUM_OUT - 1);
    localparam logic [AW-1:0] LP_STEP     = AW'(STRIDE);

    ifmap_spad_state_t r_state;
    ifmap_spad_state_t w_state_nxt;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_base;
    logic [KW-1:0] r_k;
    logic [WW-1:0] r_win;

    logic          w_we;
    logic          w_wr_last;
    logic          w_rd_fire;
    logic          w_k_last;
    logic          w_win_last;
    logic [AW-1:0] w_raddr;

    assign w_wr_last  = (r_wr_ptr == LP_WR_LAST);
    assign w_k_last   = (r_k == LP_K_LAST);
    assign w_win_last = (r_win == LP_WIN_LAST);
    // A pixel offered during clear is dropped, not written.
    assign w_we       = (r_state == LOAD) && i_in_valid && !i_clear;
    assign w_rd_fire  = (r_state == READ) && i_out_ready;
    // base+k stays within DEPTH-1 because the last window ends at DEPTH-1.
    assign w_raddr    = r_base + AW'(r_k);

    assign o_out_k    = r_k;
    assign o_out_win  = r_win;
    assign o_out_last = (r_state == READ) && w_k_last;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; clear overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid && w_wr_last) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                o_out_valid = 1'b1;
                if (i_out_ready && w_k_last && w_win_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_done      = 1'b1;
                w_state_nxt = LOAD;
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
        if (i_clear) begin
            w_state_nxt = LOAD;
        end
    end

    // Write pointer and window walk counters.
    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            r_wr_ptr <= '0;
            r_k      <= '0;
            r_win    <= '0;
            r_base   <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_fire) begin
                if (!w_k_last) begin
                    r_k <= r_k + 1'b1;
                end else begin
                    r_k <= '0;
                    if (w_win_last) begin
                        r_win  <= '0;
                        r_base <= '0;
                    end else begin
                        r_win  <= r_win + 1'b1;
                        r_base <= r_base + LP_STEP;
                    end
                end
            end
        end
    end

    ifmap_spad_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_in_data),
        .i_raddr (w_raddr),
        .o_rdata (o_out_data)
    );

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
// Bench for ifmap_spad_ctrl: default-size instance checked every cycle
// against a row/beat-position model, plus a DEPTH=9 STRIDE=2 instance
// checked against hand-written window contents.
module tb_ifmap_spad_ctrl;

    localparam int DW = 16;
    localparam int DEPTH = 12;
    localparam int K = 3;
    localparam int S = 1;
    localparam int NO = (DEPTH - K) / S + 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic          i_clear = 1'b0;
    logic          i_in_valid = 1'b0;
    logic [DW-1:0] i_in_data = '0;
    logic          o_in_ready;
    logic          o_out_valid;
    logic          i_out_ready = 1'b1;
    logic [DW-1:0] o_out_data;
    logic [1:0]    o_out_k;
    logic [3:0]    o_out_win;
    logic          o_out_last;
    logic          o_done;

    logic          d2_clear = 1'b0;
    logic          d2_in_valid = 1'b0;
    logic [DW-1:0] d2_in_data = '0;
    logic          d2_in_ready;
    logic          d2_out_valid;
    logic          d2_out_ready = 1'b1;
    logic [DW-1:0] d2_out_data;
    logic [1:0]    d2_out_k;
    logic [1:0]    d2_out_win;
    logic          d2_out_last;
    logic          d2_done;

    always #5 clk = ~clk;

    ifmap_spad_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .KERNEL(K), .STRIDE(S)) dut (
        .clk(clk), .rstn(rstn), .i_clear(i_clear),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_k(o_out_k), .o_out_win(o_out_win), .o_out_last(o_out_last), .o_done(o_done)
    );

    ifmap_spad_ctrl #(.DATA_WIDTH(DW), .DEPTH(9), .KERNEL(3), .STRIDE(2)) dut2 (
        .clk(clk), .rstn(rstn), .i_clear(d2_clear),
        .i_in_valid(d2_in_valid), .i_in_data(d2_in_data), .o_in_ready(d2_in_ready),
        .o_out_valid(d2_out_valid), .i_out_ready(d2_out_ready), .o_out_data(d2_out_data),
        .o_out_k(d2_out_k), .o_out_win(d2_out_win), .o_out_last(d2_out_last), .o_done(d2_done)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model of the default instance ----------------
    // phase: 0 loading, 1 replaying, 2 done pulse
    int m_phase = 0;
    int m_loaded = 0;
    int m_beat = 0;
    int m_mem [DEPTH];
    bit m_ok [DEPTH];
    bit chk_on = 1'b0;
    bit rdy_rand = 1'b0;

    int tcyc = 0;
    int dcount = 0;
    int last_done_cyc = 0;
    logic [DW-1:0] q_data [$];
    logic          q_last [$];
    logic [3:0]    q_win  [$];

    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_k;
    logic [3:0]    prev_win;
    logic          prev_last;
    int            ek, ew, eidx;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) tcyc = 0; else tcyc++;
            if (chk_on) begin
                ek = 0; ew = 0;
                if (m_phase == 1) begin
                    ek = m_beat % K;
                    ew = m_beat / K;
                end
                eidx = ew * S + ek;
                check("in_ready", o_in_ready, (m_phase == 0));
                check("out_valid", o_out_valid, (m_phase == 1));
                check("done", o_done, (m_phase == 2));
                check("out_k", o_out_k, ek);
                check("out_win", o_out_win, ew);
                check("out_last", o_out_last, (m_phase == 1) && (ek == K - 1));
                if (m_ok[eidx]) check("out_data", o_out_data, m_mem[eidx]);
                if (prev_stall) begin
                    check("stall_data", o_out_data, prev_data);
                    check("stall_k", o_out_k, prev_k);
                    check("stall_win", o_out_win, prev_win);
                    check("stall_last", o_out_last, prev_last);
                end
            end
            prev_stall = rstn && !i_clear && o_out_valid && !i_out_ready;
            prev_data = o_out_data;
            prev_k = o_out_k;
            prev_win = o_out_win;
            prev_last = o_out_last;
            if (rstn && !i_clear && o_out_valid && i_out_ready) begin
                q_data.push_back(o_out_data);
                q_last.push_back(o_out_last);
                q_win.push_back(o_out_win);
            end
            if (o_done) begin
                dcount++;
                last_done_cyc = tcyc;
            end
            if (!rstn || i_clear) begin
                m_phase = 0; m_loaded = 0; m_beat = 0;
            end else begin
                case (m_phase)
                    0: if (i_in_valid) begin
                        m_mem[m_loaded] = int'(i_in_data);
                        m_ok[m_loaded] = 1'b1;
                        m_loaded++;
                        if (m_loaded == DEPTH) begin
                            m_loaded = 0;
                            m_phase = 1;
                        end
                    end
                    1: if (i_out_ready) begin
                        m_beat++;
                        if (m_beat == NO * K) begin
                            m_beat = 0;
                            m_phase = 2;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // out_ready driver: held high or random bubbles
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Push n pixels first, first+1, ...; bubble inserts random in_valid gaps.
    task automatic load_row(input int first, input int n, input bit bubble);
        bit acc;
        int tries;
        for (int i = 0; i < n; i++) begin
            i_in_data = DW'(first + i);
            tries = 0;
            do begin
                i_in_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
                acc = i_in_valid && o_in_ready;
                @(posedge clk);
                #1;
                tries++;
            end while (!acc && tries < 100);
            if (!acc) check("load_timeout", 0, 1);
        end
        i_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        check("done_timeout", seen, 1);
        @(posedge clk);
        #1;
    endtask

    // Row of pixels base+1..base+DEPTH with stride 1: beat b = window b/3, pixel b%3.
    task automatic check_row(input int base, input int off);
        check("beat_count", (q_data.size() >= off + 30), 1);
        for (int b = 0; b < 30; b++) begin
            if (off + b < q_data.size()) begin
                check("row_data", q_data[off + b], base + b / 3 + b % 3 + 1);
                check("row_last", q_last[off + b], (b % 3 == 2));
                check("row_win", q_win[off + b], b / 3);
            end
        end
    endtask

    int d0;
    int d2_exp [12] = '{0, 1, 2, 2, 3, 4, 4, 5, 6, 6, 7, 8};
    logic [DW-1:0] d2_q [$];
    logic          d2_ql [$];
    logic [1:0]    d2_qw [$];
    int c_beat, c_done;
    bit d2_seen;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        check("rst_in_ready", o_in_ready, 1);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_out_k", o_out_k, 0);
        check("rst_out_win", o_out_win, 0);
        check("rst_out_last", o_out_last, 0);
        check("d2_rst_in_ready", d2_in_ready, 1);
        check("d2_rst_out_valid", d2_out_valid, 0);
        check("d2_rst_done", d2_done, 0);

        // row 1..12, everything held ready
        rstn = 1'b1;
        load_row(1, 12, 1'b0);
        wait_done(100);
        check("done_cycle", last_done_cyc, 43);
        check("s1_beats", q_data.size(), 30);
        check_row(0, 0);
        check("s1_first", q_data[0], 1);
        check("s1_last", q_data[29], 12);

        // same row with random bubbles on both sides
        q_data.delete(); q_last.delete(); q_win.delete();
        rdy_rand = 1'b1;
        load_row(1, 12, 1'b1);
        wait_done(400);
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        check("rand_beats", q_data.size(), 30);
        check_row(0, 0);

        // clear at window 4, k=1
        load_row(51, 12, 1'b0);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 100 && !hit; i++) begin
                if (o_out_valid && o_out_win == 4 && o_out_k == 1) hit = 1'b1;
                else begin @(posedge clk); #1; end
            end
            check("clear_reach_w4k1", hit, 1);
        end
        d0 = dcount;
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        check("clr_in_ready", o_in_ready, 1);
        check("clr_out_valid", o_out_valid, 0);
        check("clr_out_win", o_out_win, 0);
        q_data.delete(); q_last.delete(); q_win.delete();
        load_row(200, 12, 1'b0);
        wait_done(100);
        check("clr_done_count", dcount - d0, 1);
        check("clr_first", q_data[0], 200);
        check_row(199, 0);

        // reset during load after 5 pixels
        load_row(300, 5, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", o_in_ready, 1);
        check("mid_rst_out_valid", o_out_valid, 0);
        check("mid_rst_done", o_done, 0);
        rstn = 1'b1;
        q_data.delete(); q_last.delete(); q_win.delete();
        load_row(400, 11, 1'b0);
        check("after11_out_valid", o_out_valid, 0);
        check("after11_in_ready", o_in_ready, 1);
        load_row(411, 1, 1'b0);
        check("after12_out_valid", o_out_valid, 1);
        wait_done(100);
        check_row(399, 0);

        // back-to-back rows
        q_data.delete(); q_last.delete(); q_win.delete();
        d0 = dcount;
        load_row(1, 12, 1'b0);
        wait_done(100);
        load_row(101, 12, 1'b0);
        wait_done(100);
        check("b2b_done_count", dcount - d0, 2);
        check("b2b_beats", q_data.size(), 60);
        check_row(0, 0);
        check_row(100, 30);
        check("b2b_w0_0", q_data[30], 101);
        check("b2b_w0_1", q_data[31], 102);
        check("b2b_w0_2", q_data[32], 103);

        // DEPTH=9 KERNEL=3 STRIDE=2 instance, pixels 0..8
        for (int i = 0; i < 9; i++) begin
            d2_in_valid = 1'b1;
            d2_in_data = DW'(i);
            @(posedge clk);
            #1;
        end
        d2_in_valid = 1'b0;
        d2_seen = 1'b0;
        c_beat = -10;
        c_done = 0;
        for (int i = 0; i < 40 && !d2_seen; i++) begin
            @(negedge clk);
            if (d2_done) begin
                d2_seen = 1'b1;
                c_done = i;
            end
            if (d2_out_valid && d2_out_ready) begin
                d2_q.push_back(d2_out_data);
                d2_ql.push_back(d2_out_last);
                d2_qw.push_back(d2_out_win);
                c_beat = i;
            end
        end
        check("d2_done_seen", d2_seen, 1);
        check("d2_beats", d2_q.size(), 12);
        check("d2_done_after_last", c_done - c_beat, 1);
        for (int b = 0; b < 12; b++) begin
            if (b < d2_q.size()) begin
                check("d2_data", d2_q[b], d2_exp[b]);
                check("d2_last", d2_ql[b], (b % 3 == 2));
                check("d2_win", d2_qw[b], b / 3);
            end
        end
        @(posedge clk);
        #1;
        check("d2_back_to_load", d2_in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
